// File: rtl/writeback_unit_if.sv
// Writeback bundle: ALU/load result inputs, scoreboard issue, RF write port.
// Master drives results and issue; slave (writeback_unit) drives the rest.
interface writeback_unit_if;
  logic       aluValid;
  logic [2:0] aluDest;
  logic [7:0] aluData;
  logic       loadValid;
  logic [2:0] loadDest;
  logic [7:0] loadData;
  logic       loadReady;
  logic       issueValid;
  logic [2:0] issueDest;
  logic [7:0] busy;
  logic       writeEn;
  logic [2:0] dest;
  logic [7:0] data;

  modport master (
    output aluValid, aluDest, aluData,
    output loadValid, loadDest, loadData,
    output issueValid, issueDest,
    input  loadReady, busy,
    input  writeEn, dest, data
  );

  modport slave (
    input  aluValid, aluDest, aluData,
    input  loadValid, loadDest, loadData,
    input  issueValid, issueDest,
    output loadReady, busy,
    output writeEn, dest, data
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback arbiter: ALU > queued load > bypassed load, 2-entry load FIFO.
// Optional pending-load scoreboard compiled in with WB_SCOREBOARD_EN.
module writeback_unit (
  input logic             clk,
  input logic             resetN,
  writeback_unit_if.slave bus
);

  typedef struct packed {
    logic [2:0] dest;
    logic [7:0] data;
  } ent_t;

  ent_t       q [2];
  ent_t       s_q [2];
  ent_t       n_q [2];
  logic [1:0] cnt;
  logic [1:0] s_cnt;
  logic [1:0] n_cnt;

  ent_t       ld;
  logic       accept;
  logic       hit0;
  logic       hit1;
  logic       ld_kill;
  logic       sel_alu;
  logic       sel_head;
  logic       sel_load;
  logic       push;

  logic       wr_en;
  logic [2:0] wr_dest;
  logic [7:0] wr_data;

  assign ld            = '{dest: bus.loadDest, data: bus.loadData};
  assign bus.loadReady = (cnt != 2'd2);
  assign accept        = bus.loadValid && bus.loadReady;

  assign hit0 = bus.aluValid && (cnt != 2'd0)
             && (q[0].dest == bus.aluDest);
  assign hit1 = bus.aluValid && (cnt == 2'd2)
             && (q[1].dest == bus.aluDest);
  assign ld_kill = bus.aluValid && accept
                && (bus.loadDest == bus.aluDest);

  assign sel_alu  = bus.aluValid;
  assign sel_head = !bus.aluValid && (cnt != 2'd0);
  assign sel_load = !bus.aluValid && (cnt == 2'd0) && accept;
  assign push     = accept && !sel_load && !ld_kill;

  // Next FIFO: drop killed entries or pop head, then append the push.
  always_comb begin
    s_q   = q;
    s_cnt = 2'd0;
    if (bus.aluValid) begin
      if ((cnt != 2'd0) && !hit0) begin
        s_q[0] = q[0];
        s_cnt  = 2'd1;
      end
      if ((cnt == 2'd2) && !hit1) begin
        if (s_cnt == 2'd0) s_q[0] = q[1];
        else               s_q[1] = q[1];
        s_cnt = s_cnt + 2'd1;
      end
    end else if (cnt == 2'd2) begin
      s_q[0] = q[1];
      s_cnt  = 2'd1;
    end
    n_q   = s_q;
    n_cnt = s_cnt;
    if (push) begin
      if (s_cnt == 2'd0) n_q[0] = ld;
      else               n_q[1] = ld;
      n_cnt = s_cnt + 2'd1;
    end
  end

  // FIFO state; reset flushes anything queued.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt  <= 2'd0;
      q[0] <= '0;
      q[1] <= '0;
    end else begin
      cnt  <= n_cnt;
      q[0] <= n_q[0];
      q[1] <= n_q[1];
    end
  end

  // Register-file write port; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      wr_en   <= 1'b0;
      wr_dest <= 3'd0;
      wr_data <= 8'd0;
    end else begin
      wr_en <= sel_alu || sel_head || sel_load;
      unique case (1'b1)
        sel_alu: begin
          wr_dest <= bus.aluDest;
          wr_data <= bus.aluData;
        end
        sel_head: begin
          wr_dest <= q[0].dest;
          wr_data <= q[0].data;
        end
        sel_load: begin
          wr_dest <= bus.loadDest;
          wr_data <= bus.loadData;
        end
        default: begin
          wr_dest <= wr_dest;
          wr_data <= wr_data;
        end
      endcase
    end
  end

  assign bus.writeEn = wr_en;
  assign bus.dest    = wr_dest;
  assign bus.data    = wr_data;

`ifdef WB_SCOREBOARD_EN
  logic [7:0] busy_q;
  logic [7:0] set_m;
  logic [7:0] clr_m;

  // Clear on load writes and WAW-killed loads; a new issue overrides.
  always_comb begin
    set_m = 8'd0;
    clr_m = 8'd0;
    if (sel_head) clr_m[q[0].dest]    = 1'b1;
    if (sel_load) clr_m[bus.loadDest] = 1'b1;
    if (hit0)     clr_m[q[0].dest]    = 1'b1;
    if (hit1)     clr_m[q[1].dest]    = 1'b1;
    if (ld_kill)  clr_m[bus.loadDest] = 1'b1;
    if (bus.issueValid) set_m[bus.issueDest] = 1'b1;
  end

  // Pending-load bits.
  always_ff @(posedge clk) begin
    if (!resetN) busy_q <= 8'd0;
    else         busy_q <= (busy_q & ~clr_m) | set_m;
  end

  assign bus.busy = busy_q;
`else
  logic unused_issue;
  assign unused_issue = ^{bus.issueValid, bus.issueDest};
  assign bus.busy     = 8'd0;
`endif

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on posedge.
- resetN  in  1  synchronous reset, active-low, sampled on posedge clk.
- aluValid  in  1  ALU result present this cycle.
- aluDest  in  3  ALU destination register.
- aluData  in  8  ALU result.
- loadValid  in  1  load result offered.
- loadDest  in  3  load destination register.
- loadData  in  8  load result.
- loadReady  out  1  block can accept a load result this cycle.
- issueValid  in  1  load instruction issued this cycle (scoreboard set).
- issueDest  in  3  destination of the issued load.
- busy  out  8  per-register pending-load bits.
- writeEn  out  1  register-file write strobe.
- dest  out  3  register-file write address.
- data  out  8  register-file write data.
REQ-002 writeEn, dest and data SHALL be registered outputs; loadReady and busy SHALL be driven directly from registered state.

Function
REQ-003 A load SHALL be accepted only in a cycle where loadValid=1 and loadReady=1; offers with loadReady=0 SHALL be ignored with no state change.
REQ-004 The block SHALL contain a 2-entry FIFO of load results {dest, data}. loadReady SHALL be 1 when the registered entry count is less than 2.
REQ-005 Each cycle, the write-port source SHALL follow this priority:
- ALU result, if aluValid=1.
- Otherwise the FIFO head, if the FIFO is non-empty.
- Otherwise a load accepted this cycle, as a direct path that bypasses the FIFO.
- Otherwise no write.
REQ-006 The selected source SHALL appear on writeEn/dest/data on the next posedge; the ALU-to-write latency SHALL be exactly 1 cycle.
REQ-007 An accepted load that is not selected as the write source SHALL be pushed to the FIFO tail in the same cycle.
REQ-008 Push and pop in the same cycle SHALL leave the count unchanged and preserve FIFO order.
REQ-009 When the FIFO is full, a pop SHALL NOT make loadReady=1 in the same cycle.
REQ-010 Load results SHALL be written in acceptance order.
REQ-011 WAW kill: when aluValid=1, every FIFO entry whose dest equals aluDest SHALL be discarded that cycle, and the count reduced accordingly. An accepted load in the same cycle with loadDest=aluDest SHALL also be discarded.
REQ-012 When no source is selected, writeEn SHALL be 0 and dest/data SHALL hold their previous values.
REQ-013 Scoreboard: issueValid=1 SHALL set busy[issueDest] at the next posedge.
REQ-014 A load-sourced write, or a load discarded by REQ-011, SHALL clear busy[dest] at the next posedge.
REQ-015 If a set and a clear target the same bit in the same cycle, the set SHALL win.
REQ-016 ALU-sourced writes SHALL NOT modify busy.

Reset
REQ-017 While resetN=0 at a posedge, the block SHALL reset:
- FIFO: emptied (count=0); queued loads are flushed, including mid-operation.
- writeEn=0, dest=0, data=0, busy=0.
- All inputs are ignored during reset.
REQ-018 On the first cycle after reset, loadReady SHALL be 1.

Configuration
REQ-019 Macro WB_SCOREBOARD_EN SHALL compile in the scoreboard.
REQ-020 With WB_SCOREBOARD_EN defined, REQ-013..REQ-016 SHALL apply.
REQ-021 Without WB_SCOREBOARD_EN, busy SHALL be constant 0 and issueValid/issueDest SHALL be ignored. All other behaviour SHALL be identical.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- aluValid=1, aluDest=3, aluData=0x5A, FIFO empty -> next cycle writeEn=1, dest=3, data=0x5A; following idle cycle writeEn=0.
- Load (dest 2, 0x11) accepted alone, FIFO empty -> next cycle writeEn=1, dest=2, data=0x11; count stays 0.
- ALU (dest 1) held valid 3 cycles while loads (dest 4, 0xA0) then (dest 5, 0xB0) are offered -> both queued, loadReady=0 after the second; third load offer ignored; after ALU stops, writes dest 4 then dest 5.
- FIFO holds (dest 6, 0x33); aluValid=1, aluDest=6, aluData=0x77 -> write dest 6 = 0x77; entry discarded; count=0; busy[6] cleared (WB_SCOREBOARD_EN).
- issueValid=1, issueDest=7, then load dest 7 written -> busy=0x80 for the pending cycles, 0x00 the cycle after the write; set and clear of bit 7 in the same cycle -> busy[7]=1.
- FIFO full, resetN=0 for one cycle -> count=0, writeEn=0, busy=0, loadReady=1 next cycle; flushed entries are never written.
